// File: rtl/img_proc_pkg.sv
// Shared constants for the binary image-processing blocks:
// morphology mode codes, morph FSM states and a 9-bit popcount.
package img_proc_pkg;

   localparam logic [1:0] MORPH_BYPASS = 2'b00;
   localparam logic [1:0] MORPH_ERODE  = 2'b01;
   localparam logic [1:0] MORPH_DILATE = 2'b10;
   localparam logic [1:0] MORPH_MAJ    = 2'b11;

   typedef enum logic {
      WAIT_VS = 1'b0,
      ACTIVE  = 1'b1
   } morph_state_e;

   function automatic logic [3:0] popcount9(input logic [8:0] w);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 9; i++) begin
         n = n + {3'b000, w[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for sync/timing signals.
// Ports: clk_i, rst_i (async high), d_i in, q_o = d_i delayed DEPTH cycles.
module sync_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sr_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= '0;
         end
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/binary_morph_3x3.sv
// 3x3 binary morphology (bypass/erode/dilate/majority) with border fill.
// In: video_clk, rst, mode, video_vs/hs, matrix_de, matrix11..33.
// Out: out_vs/hs (vs/hs + SYNC_DLY+2), out_de/out_data (+2), line_err.
module binary_morph_3x3
   import img_proc_pkg::*;
#(
   parameter int   IMG_WIDTH  = 1920,
   parameter int   IMG_HEIGHT = 1080,
   parameter int   SYNC_DLY   = 2,
   parameter logic BORDER_VAL = 1'b0
) (
   input  logic       video_clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic       video_vs,
   input  logic       video_hs,
   input  logic       matrix_de,
   input  logic       matrix11,
   input  logic       matrix12,
   input  logic       matrix13,
   input  logic       matrix21,
   input  logic       matrix22,
   input  logic       matrix23,
   input  logic       matrix31,
   input  logic       matrix32,
   input  logic       matrix33,
   output logic       out_vs,
   output logic       out_hs,
   output logic       out_de,
   output logic       out_data,
   output logic       line_err
);

   localparam int XW = $clog2(IMG_WIDTH + 1);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_FULL = XW'(IMG_WIDTH);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   morph_state_e   state_q;
   logic [1:0]     mode_q;
   logic           vs_q, fs_q, de_q;
   logic [XW-1:0]  x_q;
   logic [YW-1:0]  y_q;
   logic           line_err_q;

   logic [8:0]     win;
   logic           and9_q, or9_q, maj_q, ctr_q, brd_q, de1_q;
   logic           sel_d, data_d;
   logic           out_de_q, out_data_q;

   assign win = {matrix11, matrix12, matrix13,
                 matrix21, matrix22, matrix23,
                 matrix31, matrix32, matrix33};

   // Frame start is a registered rising edge of vs; it
   // overrides any line bookkeeping on the same cycle.
   always_ff @(posedge video_clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_VS;
         mode_q     <= MORPH_BYPASS;
         vs_q       <= 1'b0;
         fs_q       <= 1'b0;
         de_q       <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         line_err_q <= 1'b0;
      end else begin
         vs_q <= video_vs;
         fs_q <= video_vs & ~vs_q;
         de_q <= matrix_de;
         if (fs_q) begin
            state_q    <= ACTIVE;
            mode_q     <= mode;
            x_q        <= '0;
            y_q        <= '0;
            line_err_q <= 1'b0;
         end else if (matrix_de) begin
            x_q <= x_q + XW'(1);
         end else if (de_q) begin
            x_q <= '0;
            if (y_q != Y_LAST) y_q <= y_q + YW'(1);
            if (x_q != X_FULL) line_err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge video_clk or posedge rst) begin
      if (rst) begin
         and9_q <= 1'b0;
         or9_q  <= 1'b0;
         maj_q  <= 1'b0;
         ctr_q  <= 1'b0;
         brd_q  <= 1'b0;
         de1_q  <= 1'b0;
      end else begin
         and9_q <= &win;
         or9_q  <= |win;
         maj_q  <= popcount9(win) >= 4'd5;
         ctr_q  <= matrix22;
         brd_q  <= (x_q == '0) || (x_q == X_LAST) ||
                   (y_q == '0) || (y_q == Y_LAST);
         de1_q  <= matrix_de;
      end
   end

   always_comb begin
      sel_d = 1'b0;
      unique case (mode_q)
         MORPH_BYPASS: sel_d = ctr_q;
         MORPH_ERODE:  sel_d = and9_q;
         MORPH_DILATE: sel_d = or9_q;
         MORPH_MAJ:    sel_d = maj_q;
         default:      sel_d = 1'b0;
      endcase
   end

   // Until a frame start is seen the data path is held at 0.
   always_comb begin
      data_d = 1'b0;
      if (state_q == ACTIVE && de1_q) begin
         data_d = brd_q ? BORDER_VAL : sel_d;
      end
   end

   always_ff @(posedge video_clk or posedge rst) begin
      if (rst) begin
         out_de_q   <= 1'b0;
         out_data_q <= 1'b0;
      end else begin
         out_de_q   <= de1_q;
         out_data_q <= data_d;
      end
   end

   sync_delay_line #(
      .WIDTH(2),
      .DEPTH(SYNC_DLY + 2)
   ) u_sync_dly (
      .clk_i(video_clk),
      .rst_i(rst),
      .d_i  ({video_vs, video_hs}),
      .q_o  ({out_vs, out_hs})
   );

   assign out_de   = out_de_q;
   assign out_data = out_data_q;
   assign line_err = line_err_q;

endmodule

// File: tb/tb_binary_morph_3x3.sv
// Randomised bench for binary_morph_3x3 (8x6 image, SYNC_DLY=2)
// against a per-pixel behavioural reference model.
module tb_binary_morph_3x3;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int SD = 2;
   localparam int HN = 4096;

   logic       video_clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       video_vs = 1'b0, video_hs = 1'b0, matrix_de = 1'b0;
   logic       matrix11 = 1'b0, matrix12 = 1'b0, matrix13 = 1'b0;
   logic       matrix21 = 1'b0, matrix22 = 1'b0, matrix23 = 1'b0;
   logic       matrix31 = 1'b0, matrix32 = 1'b0, matrix33 = 1'b0;
   logic       out_vs, out_hs, out_de, out_data, line_err;

   int total = 0;
   int bad   = 0;

   always #5 video_clk = ~video_clk;

   binary_morph_3x3 #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .SYNC_DLY  (SD),
      .BORDER_VAL(1'b0)
   ) dut (
      .video_clk(video_clk),
      .rst      (rst),
      .mode     (mode),
      .video_vs (video_vs),
      .video_hs (video_hs),
      .matrix_de(matrix_de),
      .matrix11 (matrix11),
      .matrix12 (matrix12),
      .matrix13 (matrix13),
      .matrix21 (matrix21),
      .matrix22 (matrix22),
      .matrix23 (matrix23),
      .matrix31 (matrix31),
      .matrix32 (matrix32),
      .matrix33 (matrix33),
      .out_vs   (out_vs),
      .out_hs   (out_hs),
      .out_de   (out_de),
      .out_data (out_data),
      .line_err (line_err)
   );

   typedef struct packed {
      logic       r;
      logic       v;
      logic       h;
      logic       d;
      logic [1:0] md;
      logic [8:0] w;
      logic       ed;
   } cyc_t;

   logic vs_h [HN];
   logic hs_h [HN];
   logic de_h [HN];
   logic ed_h [HN];
   int   cyc = 0;
   int   chk_from = 0;
   int   o_idx = 0;
   logic o_vs, o_hs, o_de, o_data;
   logic [8:0] dwin [4];

   // Reference operator: count ones, apply the named rule.
   function automatic logic ref_op(input logic [1:0] md,
                                   input logic [8:0] w);
      int n;
      n = 0;
      for (int i = 0; i < 9; i++) n += int'(w[i]);
      case (md)
         2'd0:    return w[4];
         2'd1:    return n == 9;
         2'd2:    return n > 0;
         default: return n >= 5;
      endcase
   endfunction

   function automatic logic is_brd(input int x, input int y);
      return x == 0 || x == W-1 || y == 0 || y == H-1;
   endfunction

   // Window of a checkerboard image; row 0 = line above, col 2 = right.
   function automatic logic [8:0] cb_win(input int x, input int y);
      logic [8:0] w;
      int xx, yy;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            yy = y + r - 1;
            xx = x + c - 1;
            if (yy >= 0 && yy < H && xx >= 0 && xx < W)
               w[8-(r*3+c)] = ((xx + yy) % 2) == 1;
         end
      end
      return w;
   endfunction

   task automatic step(input cyc_t c);
      @(posedge video_clk);
      #1;
      o_idx  = cyc;
      o_vs   = out_vs;
      o_hs   = out_hs;
      o_de   = out_de;
      o_data = out_data;
      rst       = c.r;
      mode      = c.md;
      video_vs  = c.v;
      video_hs  = c.h;
      matrix_de = c.d;
      {matrix11, matrix12, matrix13,
       matrix21, matrix22, matrix23,
       matrix31, matrix32, matrix33} = c.w;
      vs_h[cyc] = c.v;
      hs_h[cyc] = c.h;
      de_h[cyc] = c.d;
      ed_h[cyc] = c.ed;
      cyc++;
   endtask

   // One frame: vs pulse, gap, H lines (optional short line,
   // mid-frame mode change, reset before a line), trailer.
   task automatic run_frame(input logic [1:0] md, input int kind,
                            input int short_ln, input int chg_ln,
                            input int rst_ln);
      cyc_t q[$];
      cyc_t c;
      logic act;
      int   k, n;
      act = 1'b1;
      k = 0;
      c = '0;
      c.md = md;
      c.v = 1'b1;
      q.push_back(c);
      q.push_back(c);
      c.v = 1'b0;
      repeat (4) q.push_back(c);
      for (int y = 0; y < H; y++) begin
         if (y == chg_ln) c.md = 2'b01;
         if (y == rst_ln) begin
            c.r = 1'b1;
            q.push_back(c);
            q.push_back(c);
            c.r = 1'b0;
            act = 1'b0;
         end
         c.h = 1'b1;
         q.push_back(c);
         c.h = 1'b0;
         q.push_back(c);
         q.push_back(c);
         n = (y == short_ln) ? W - 1 : W;
         for (int x = 0; x < n; x++) begin
            c.d = 1'b1;
            if (kind == 0) c.w = cb_win(x, y);
            else if (kind == 2 && !is_brd(x, y)) begin
               c.w = dwin[k % 4];
               k++;
            end else c.w = 9'($urandom);
            c.ed = act && !is_brd(x, y) && ref_op(md, c.w);
            q.push_back(c);
         end
         c.d = 1'b0;
         c.ed = 1'b0;
         c.w = '0;
         repeat (3) q.push_back(c);
      end
      repeat (5) q.push_back(c);
      foreach (q[i]) begin
         step(q[i]);
         if (q[i].r) chk_from = cyc;
         if (o_idx - 2 >= chk_from) begin
            total += 2;
            if (o_de !== de_h[o_idx-2]) begin
               bad++;
               $display("FAIL out_de idx=%0d got=%b exp=%b",
                        o_idx, o_de, de_h[o_idx-2]);
            end
            if (o_data !== ed_h[o_idx-2]) begin
               bad++;
               $display("FAIL out_data md=%0d idx=%0d got=%b exp=%b",
                        md, o_idx, o_data, ed_h[o_idx-2]);
            end
         end
         if (o_idx - 4 >= chk_from) begin
            total += 2;
            if (o_vs !== vs_h[o_idx-4]) begin
               bad++;
               $display("FAIL out_vs idx=%0d got=%b exp=%b",
                        o_idx, o_vs, vs_h[o_idx-4]);
            end
            if (o_hs !== hs_h[o_idx-4]) begin
               bad++;
               $display("FAIL out_hs idx=%0d got=%b exp=%b",
                        o_idx, o_hs, hs_h[o_idx-4]);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge video_clk);
      #1;
      total += 5;
      if ({out_vs, out_hs, out_de, out_data, line_err} !== 5'b0) begin
         bad += 5;
         $display("FAIL reset_outs got=%b exp=00000",
                  {out_vs, out_hs, out_de, out_data, line_err});
      end
      rst = 1'b0;
      chk_from = cyc;
   endtask

   task automatic test_bypass;
      run_frame(2'b00, 0, -1, -1, -1);
      run_frame(2'b00, 1, -1, -1, -1);
      total++;
      if (line_err !== 1'b0) begin
         bad++;
         $display("FAIL bypass_line_err got=%b exp=0", line_err);
      end
   endtask

   task automatic test_erode;
      dwin[0] = 9'b110_111_111;
      dwin[1] = 9'b111_111_111;
      dwin[2] = 9'b111_101_111;
      dwin[3] = 9'($urandom);
      run_frame(2'b01, 2, -1, -1, -1);
   endtask

   task automatic test_dilate;
      dwin[0] = 9'b000_000_100;
      dwin[1] = 9'b000_000_000;
      dwin[2] = 9'b000_010_000;
      dwin[3] = 9'($urandom);
      run_frame(2'b10, 2, -1, -1, -1);
   endtask

   task automatic test_majority;
      dwin[0] = 9'b111_100_000;
      dwin[1] = 9'b111_110_000;
      dwin[2] = 9'b101_010_101;
      dwin[3] = 9'b100_100_100;
      run_frame(2'b11, 2, -1, 2, -1);
      run_frame(2'b01, 1, -1, -1, -1);
   endtask

   task automatic test_line_err;
      run_frame(2'b10, 1, 1, -1, -1);
      total++;
      if (line_err !== 1'b1) begin
         bad++;
         $display("FAIL line_err_held got=%b exp=1", line_err);
      end
      run_frame(2'b11, 1, -1, -1, -1);
      total++;
      if (line_err !== 1'b0) begin
         bad++;
         $display("FAIL line_err_clear got=%b exp=0", line_err);
      end
   endtask

   task automatic test_reset_mid;
      run_frame(2'b10, 1, -1, -1, 3);
      total++;
      if (line_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_line_err got=%b exp=0", line_err);
      end
      run_frame(2'b11, 1, -1, -1, -1);
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_erode();
      test_dilate();
      test_majority();
      test_line_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
